alu_design_core: RTL and testbench

//  Multi-operation integer ALU with a start/end handshake. Used as the arithmetic leaf under the ALU_intf bus.

---
 rtl/alu_package.sv | 34 +++
 rtl/alu_mul_pipe.sv | 63 ++++++
 rtl/alu_design_core.sv | 194 +++++++++++++++++++
 tb/tb_alu_design_core.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_package.sv
`default_nettype none
// ============================================================================
//  Module      : alu_package
//  Description : Shared constants and enumerations for the ALU datapath.
//                IN_WIDTH/OUT_WIDTH/OP_WIDTH/MUL_LAT size the datapath; op_t
//                encodes the operation select and state_t the control FSM.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_package;

    localparam int IN_WIDTH  = 16;
    localparam int OUT_WIDTH = 32;
    localparam int OP_WIDTH  = 3;
    localparam int MUL_LAT   = 3;

    typedef enum logic [OP_WIDTH-1:0] {
        NOP = 3'd0,
        ADD = 3'd1,
        SUB = 3'd2,
        MUL = 3'd3,
        AND = 3'd4,
        OR  = 3'd5,
        XOR = 3'd6,
        SHL = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MULB = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_mul_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mul_pipe
//  Description : LAT-stage registered unsigned multiplier with a valid
//                strobe travelling alongside the data.
//                Stage 0 captures the operands, stage 1 forms the product,
//                remaining stages only delay it. LAT must be >= 2.
//  Ports       : clock, reset (async, active-low)
//                i_valid / i_a / i_b  : operands, captured when i_valid = 1
//                o_valid / o_product  : product, valid exactly LAT edges later
//  Revision    : 1.0  initial release
// ============================================================================
module alu_mul_pipe #(
    parameter int IN_WIDTH  = alu_package::IN_WIDTH,
    parameter int OUT_WIDTH = alu_package::OUT_WIDTH,
    parameter int LAT       = alu_package::MUL_LAT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_valid,
    input  logic [IN_WIDTH-1:0]  i_a,
    input  logic [IN_WIDTH-1:0]  i_b,
    output logic                 o_valid,
    output logic [OUT_WIDTH-1:0] o_product
);

    logic [IN_WIDTH-1:0]  r_a;
    logic [IN_WIDTH-1:0]  r_b;
    logic [LAT-1:0]       r_vld;
    logic [OUT_WIDTH-1:0] r_prod [1:LAT-1];

    logic [OUT_WIDTH-1:0] w_a_ext;
    logic [OUT_WIDTH-1:0] w_b_ext;

    assign w_a_ext = {{(OUT_WIDTH-IN_WIDTH){1'b0}}, r_a};
    assign w_b_ext = {{(OUT_WIDTH-IN_WIDTH){1'b0}}, r_b};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_vld <= '0;
            for (int i = 1; i < LAT; i++) begin
                r_prod[i] <= '0;
            end
        end else begin
            if (i_valid) begin
                r_a <= i_a;
                r_b <= i_b;
            end
            r_vld     <= {r_vld[LAT-2:0], i_valid};
            r_prod[1] <= w_a_ext * w_b_ext;
            for (int i = 2; i < LAT; i++) begin
                r_prod[i] <= r_prod[i-1];
            end
        end
    end

    assign o_valid   = r_vld[LAT-1];
    assign o_product = r_prod[LAT-1];

endmodule
`default_nettype wire

// File: rtl/alu_design_core.sv
`default_nettype none
// ============================================================================
//  Module      : alu_design_core
//  Description : Multi-operation integer ALU with start/end handshake.
//                A rising edge on start_op while IDLE captures A, B, op_sel.
//                Non-MUL ops complete one cycle after accept; MUL runs
//                through alu_mul_pipe and completes MUL_LAT cycles after
//                accept. Completion writes result and pulses end_op.
//  Ports       : clock, reset (async, active-low)
//                A, B      : unsigned operands
//                start_op  : request, accepted on its rising edge in IDLE
//                op_sel    : operation select (op_t)
//                result    : registered result, held until next completion
//                end_op    : one-cycle completion pulse
//                err       : borrow / shift-overflow flag (only when the
//                            ALU_ERR_FLAG_EN macro is defined)
//  Revision    : 1.0  initial release
// ============================================================================
module alu_design_core import alu_package::*; #(
    parameter int IN_WIDTH  = alu_package::IN_WIDTH,
    parameter int OUT_WIDTH = alu_package::OUT_WIDTH,
    parameter int OP_WIDTH  = alu_package::OP_WIDTH,
    parameter int MUL_LAT   = alu_package::MUL_LAT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [IN_WIDTH-1:0]  A,
    input  logic [IN_WIDTH-1:0]  B,
    input  logic                 start_op,
    input  logic [OP_WIDTH-1:0]  op_sel,
    output logic [OUT_WIDTH-1:0] result,
    output logic                 end_op
`ifdef ALU_ERR_FLAG_EN
   ,output logic                 err
`endif
);

    localparam int c_SHAMT_W = $clog2(OUT_WIDTH);

    state_t               r_state;
    state_t               w_next;
    logic                 r_start_d;
    logic [IN_WIDTH-1:0]  r_a;
    logic [IN_WIDTH-1:0]  r_b;
    op_t                  r_op;

    logic                 w_accept;
    logic                 w_load;
    logic                 w_mul_start;
    logic                 w_mul_valid;
    logic [OUT_WIDTH-1:0] w_mul_prod;
    logic [OUT_WIDTH-1:0] w_a_ext;
    logic [OUT_WIDTH-1:0] w_b_ext;
    logic [OUT_WIDTH-1:0] w_logic_res;
    logic [OUT_WIDTH-1:0] w_res;

    // Rising edge only: a start held high across completion never retriggers.
    assign w_accept = start_op & ~r_start_d;

    assign w_a_ext = {{(OUT_WIDTH-IN_WIDTH){1'b0}}, r_a};
    assign w_b_ext = {{(OUT_WIDTH-IN_WIDTH){1'b0}}, r_b};

    // ------------------------------------------------------------------
    // Start history and operand capture
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_start_d <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= NOP;
        end else begin
            r_start_d <= start_op;
            if (r_state == IDLE && w_accept) begin
                r_a  <= A;
                r_b  <= B;
                r_op <= op_t'(op_sel);
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_load      = 1'b0;
        w_mul_start = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (op_t'(op_sel) == MUL) begin
                        w_next      = MULB;
                        w_mul_start = 1'b1;
                    end else begin
                        w_next = EXEC;
                    end
                end
            end
            EXEC: begin
                w_load = 1'b1;
                w_next = IDLE;
            end
            MULB: begin
                if (w_mul_valid) begin
                    w_load = 1'b1;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Multiplier: fed straight from the ports on the accept cycle so the
    // product lands exactly MUL_LAT edges after accept.
    // ------------------------------------------------------------------
    alu_mul_pipe #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .LAT       (MUL_LAT)
    ) u_mul (
        .clock     (clock),
        .reset     (reset),
        .i_valid   (w_mul_start),
        .i_a       (A),
        .i_b       (B),
        .o_valid   (w_mul_valid),
        .o_product (w_mul_prod)
    );

    // ------------------------------------------------------------------
    // Single-cycle logic / arithmetic / shift unit
    // ------------------------------------------------------------------
    always_comb begin
        w_logic_res = '0;
        case (r_op)
            NOP:     w_logic_res = '0;
            ADD:     w_logic_res = w_a_ext + w_b_ext;
            SUB:     w_logic_res = w_a_ext - w_b_ext;
            MUL:     w_logic_res = '0;
            AND:     w_logic_res = w_a_ext & w_b_ext;
            OR:      w_logic_res = w_a_ext | w_b_ext;
            XOR:     w_logic_res = w_a_ext ^ w_b_ext;
            SHL:     w_logic_res = w_a_ext << r_b[c_SHAMT_W-1:0];
            default: w_logic_res = '0;
        endcase
    end

    assign w_res = (r_state == MULB) ? w_mul_prod : w_logic_res;

    // ------------------------------------------------------------------
    // Result register and completion pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            result <= '0;
            end_op <= 1'b0;
        end else begin
            end_op <= w_load;
            if (w_load) begin
                result <= w_res;
            end
        end
    end

`ifdef ALU_ERR_FLAG_EN
    localparam logic [IN_WIDTH-1:0] c_SHL_LIMIT = IN_WIDTH[IN_WIDTH-1:0];

    logic w_err;

    // Borrow on SUB, or a shift distance that pushes A's top bits out.
    assign w_err = ((r_op == SUB) && (r_a < r_b)) ||
                   ((r_op == SHL) && (r_b >= c_SHL_LIMIT));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (w_load) begin
            err <= w_err;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_design_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_design_core
//  Description : Self-checking bench for alu_design_core. Directed cases for
//                reset, latency, borrow, shift, busy and retrigger behaviour,
//                then randomized ops against an arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_design_core;

    logic        clock;
    logic        reset;
    logic [15:0] A;
    logic [15:0] B;
    logic        start_op;
    logic [2:0]  op_sel;
    logic [31:0] result;
    logic        end_op;
`ifdef ALU_ERR_FLAG_EN
    logic        err;
`endif

    int n_checks;
    int n_pass;

    alu_design_core dut (
        .clock    (clock),
        .reset    (reset),
        .A        (A),
        .B        (B),
        .start_op (start_op),
        .op_sel   (op_sel),
        .result   (result),
        .end_op   (end_op)
`ifdef ALU_ERR_FLAG_EN
       ,.err      (err)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: plain arithmetic modulo 2^32.
    function automatic logic [31:0] ref_result(input int op, input int unsigned a, input int unsigned b);
        longint unsigned r;
        case (op)
            1:       r = longint'(a) + longint'(b);
            2:       r = 64'h1_0000_0000 + longint'(a) - longint'(b);
            3:       r = longint'(a) * longint'(b);
            4:       r = longint'(a & b);
            5:       r = longint'(a | b);
            6:       r = longint'(a ^ b);
            7:       r = longint'(a) * (64'd1 << (b % 32));
            default: r = 0;
        endcase
        return r[31:0];
    endfunction

    function automatic logic ref_err(input int op, input int unsigned a, input int unsigned b);
        return (op == 2 && a < b) || (op == 7 && b >= 16);
    endfunction

    // Issues one op with a clean 0->1 start edge, scrambles the operands
    // after accept, then checks latency, result, err and single-pulse.
    // start_op is left high on return.
    task automatic run_op(input int op, input int unsigned a, input int unsigned b, input string tag);
        int lat;
        logic [31:0] exp;
        exp = ref_result(op, a, b);
        @(negedge clock);
        start_op = 1'b0;
        @(negedge clock);
        A        = a[15:0];
        B        = b[15:0];
        op_sel   = op[2:0];
        start_op = 1'b1;
        @(posedge clock);
        #2;
        A      = ~a[15:0];
        B      = ~b[15:0];
        op_sel = 3'(op + 1);
        lat = 0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(posedge clock);
            #1;
            if (end_op) begin
                lat = cyc;
                break;
            end
        end
        check({tag, " latency"}, lat, (op == 3) ? 3 : 1);
        check({tag, " result"}, result, exp);
`ifdef ALU_ERR_FLAG_EN
        check({tag, " err"}, {31'b0, err}, {31'b0, ref_err(op, a, b)});
`endif
        @(posedge clock);
        #1;
        check({tag, " single pulse"}, {31'b0, end_op}, 32'd0);
        check({tag, " result hold"}, result, exp);
    endtask

    initial begin
        int pulses;
        int op;
        int unsigned a;
        int unsigned b;
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b0;
        start_op = 1'b0;
        A        = '0;
        B        = '0;
        op_sel   = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset result", result, 32'd0);
        check("reset end_op", {31'b0, end_op}, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // Directed cases
        run_op(1, 32'hFFFF, 32'h0001, "ADD carry");
        run_op(3, 32'h0008, 32'h0008, "MUL 8x8");
        run_op(2, 32'h0003, 32'h0005, "SUB borrow");
        run_op(7, 32'h00F0, 32'h0004, "SHL");
        run_op(6, 32'h00F0, 32'h0004, "XOR");
        run_op(7, 32'hFFFF, 32'h0010, "SHL 16");
        run_op(0, 32'h1234, 32'h5678, "NOP");

        // start_op held high after completion must not retrigger
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            if (end_op) pulses++;
        end
        check("held start no retrigger", pulses, 0);

        // Second start edge while MUL is busy is ignored
        @(negedge clock);
        start_op = 1'b0;
        @(negedge clock);
        A = 16'h0101; B = 16'h0203; op_sel = 3'd3; start_op = 1'b1;
        @(negedge clock);
        start_op = 1'b0;
        @(negedge clock);
        start_op = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            if (end_op) pulses++;
        end
        check("busy edge ignored pulses", pulses, 1);
        check("busy edge result", result, ref_result(3, 32'h0101, 32'h0203));

        // Asynchronous reset mid-MUL aborts it
        @(negedge clock);
        start_op = 1'b0;
        @(negedge clock);
        A = 16'h0011; B = 16'h0022; op_sel = 3'd3; start_op = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #3;
        reset    = 1'b0;
        start_op = 1'b0;
        #1;
        check("async reset result", result, 32'd0);
        check("async reset end_op", {31'b0, end_op}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock);
            #1;
            if (end_op) pulses++;
        end
        check("aborted op no end_op", pulses, 0);
        run_op(1, 32'h0007, 32'h0009, "ADD after reset");

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 7));
            a  = $urandom_range(0, 16'hFFFF);
            b  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 31) : $urandom_range(0, 16'hFFFF);
            run_op(op, a, b, $sformatf("rand%0d op%0d", i, op));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Safety net so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
